berger_mem_selftest_ctrl: RTL and testbench
===========================================

# berger_mem_selftest_ctrl

Self-test sequencer for the Berger-coded faulty memory path: encoder, 16x12 memory, unidirectional fault injector and decoder. On `start` it writes an address-dependent pattern to all 16 locations. It then reads every location twice, once fault-free and once with the configured unidirectional fault applied. It classifies each fault-phase read as detected, masked or escaped, and reports the counts, giving the bench and the top level a single handshake for a full Berger-code fault-coverage run.

## Interface
- `READ_LATENCY`, default 1: cycles from address presented to `mem_rdata`/`mem_error` valid. Legal range 1..3.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a run. Ignored unless idle.
- `cfg_pattern` input 8: base data pattern. Latched on accepted `start`.
- `cfg_fault_mask` input 12: unidirectional fault mask. Latched on accepted `start`.
- `cfg_zero_to_one` input 1: fault direction (1 = 0→1, 0 = 1→0). Latched on accepted `start`.
- `mem_data` output 8: write data to the memory path.
- `mem_addr` output 4: memory address.
- `mem_wr_en` output 1: memory write enable.
- `fault_mask` output 12: mask driven to the injector.
- `fault_enable` output 1: injector enable.
- `fault_zero_to_one` output 1: injector direction.
- `mem_rdata` input 8: decoded read data.
- `mem_error` input 1: decoder error flag.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse at run end.
- `clean_fail_cnt` output 5: fault-free reads with an error or a data mismatch.
- `detected_cnt` output 5: fault-phase reads with `mem_error`=1.
- `masked_cnt` output 5: fault-phase reads with no error and correct data.
- `escape_cnt` output 5: fault-phase reads with no error and wrong data.
- `escape_valid` output 1: first-escape record valid.
- `escape_addr` output 4: address of the first escape.

## Operation
- FSM states: IDLE → WRITE → RD_CLEAN → RD_FAULT → DONE → IDLE.
- Expected data for address a: `cfg_pattern ^ {a,a}`.
- IDLE:
  - All memory-side outputs are 0.
  - An accepted `start` latches the cfg inputs and clears all counters and the escape record.
- WRITE:
  - Issues 16 consecutive writes, addr 0..15, with `mem_wr_en`=1 and expected data.
  - Moves to RD_CLEAN after address 15.
- RD_CLEAN:
  - Issues reads of addr 0..15 on 16 consecutive cycles with `fault_enable`=0, then drains for READ_LATENCY cycles.
  - Each returned beat is compared against expected data for the address issued READ_LATENCY cycles earlier.
  - `clean_fail_cnt` increments when `mem_error`=1 or the data differs.
- RD_FAULT:
  - Same issue/drain sequence.
  - `fault_enable`=1, `fault_mask` = latched mask and `fault_zero_to_one` = latched direction, held for the whole state including drain.
  - Each beat increments exactly one of `detected_cnt`, `masked_cnt` or `escape_cnt`.
- DONE:
  - `done`=1 for one cycle, `fault_enable` returns to 0, then the FSM goes to IDLE.
- Counters hold their values after `done` until the next accepted `start`.
- Counters are 5 bits wide, maximum 16, no saturation logic required.
- `detected_cnt + masked_cnt + escape_cnt` = 16 after every completed run.
- Boundary conditions:
  - `start` while busy is ignored, including in the DONE cycle.
  - cfg input changes mid-run have no effect.
  - A mask of 0 yields masked=16.
  - A Berger-correct memory path always yields `escape_cnt`=0 and `clean_fail_cnt`=0.
- Reset mid-run: everything returns to IDLE reset values immediately. No partial results are retained.

## Timing
- Reset values: all outputs 0.
- An accepted `start` at edge T puts WRITE addr 0 on the outputs from T+1.
- Run length: 16 + 2·(16 + READ_LATENCY) cycles. `done` follows in the next cycle.
- With READ_LATENCY=1, `done` is high in cycle 51 after `start`.
- `busy`:
  - High from the cycle after `start` through the `done` cycle.
  - Low in the cycle after `done`.
- The read-issue pipeline carries a valid bit and the address, READ_LATENCY stages deep.
- Counter updates are registered one cycle after the beat is sampled.
- All counters are final when `done` is high.

## Configuration
- Macro: `BERGER_CTRL_ESCAPE_LOG_EN`.
- Defined:
  - On the first escape of a run, `escape_addr` is captured and `escape_valid` is set.
  - Later escapes do not overwrite the record.
  - The record is cleared on an accepted `start`.
- Undefined: `escape_valid` and `escape_addr` are tied to 0, and no capture registers are built.

## Structure
- Package `berger_ctrl_pkg`:
  - Constants: DATA_W=8, CODE_W=12, ADDR_W=4, DEPTH=16, CNT_W=5.
  - FSM state typedef.
  - Read-beat classification enum: CLEAN_OK, CLEAN_FAIL, DETECTED, MASKED, ESCAPE.
- Sub-module `berger_result_counter`:
  - Inputs: beat valid, classification, clear.
  - Outputs: the four counters.
  - The FSM, address generator and read pipeline stay in the top module.

## Test plan
- Pattern 0x5A, mask 0x000, direction 1 → clean_fail=0, detected=0, masked=16, escape=0, `done` in cycle 51.
- Pattern 0xA5, mask 0xFFF, direction 1 (all bits forced 1) → detected=16, masked=0, escape=0.
- Pattern 0x00, mask 0xFFF, direction 0 (all bits forced 0) → detected=16, escape=0, clean_fail=0.
- `start` pulsed again at cycles 5 and 50 of a run, and cfg inputs changed mid-run → results identical to an undisturbed run, no restart.
- `rst` low at cycle 20 (RD_CLEAN) → all outputs 0 in that cycle. A fresh `start` afterwards completes normally.
- READ_LATENCY=3 with a stub memory that returns flipped data without error at addr 7, macro defined → escape=1, `escape_valid`=1, `escape_addr`=7, `done` in cycle 55.

Source files
------------

// File: rtl/berger_mem_selftest_ctrl_pkg.sv
// rtl/berger_mem_selftest_ctrl_pkg.sv - shared constants, FSM and beat-class types for the Berger self-test controller
package berger_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_CLEAN,
    ST_RD_FAULT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLEAN_OK,
    CLEAN_FAIL,
    DETECTED,
    MASKED,
    ESCAPE
  } beat_class_t;

  // Address-dependent test pattern written to and expected back from each location.
  function automatic logic [DATA_W-1:0] expected_data(input logic [DATA_W-1:0] pattern,
                                                      input logic [ADDR_W-1:0] addr);
    return pattern ^ {addr, addr};
  endfunction

endpackage

// File: rtl/berger_mem_selftest_ctrl_if.sv
// rtl/berger_mem_selftest_ctrl_if.sv - memory path and fault injector signal bundle
interface berger_mem_selftest_ctrl_if;
  import berger_ctrl_pkg::*;

  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [CODE_W-1:0] fault_mask;
  logic              fault_enable;
  logic              fault_zero_to_one;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_error;

  modport master (
    output mem_data, mem_addr, mem_wr_en, fault_mask, fault_enable, fault_zero_to_one,
    input  mem_rdata, mem_error
  );

  modport slave (
    input  mem_data, mem_addr, mem_wr_en, fault_mask, fault_enable, fault_zero_to_one,
    output mem_rdata, mem_error
  );

endinterface

// File: rtl/berger_mem_selftest_ctrl_counter.sv
// rtl/berger_mem_selftest_ctrl_counter.sv - per-class read-beat counters for one self-test run
module berger_result_counter
  import berger_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_beat_vld,
  input  beat_class_t       i_beat_class,
  output logic [CNT_W-1:0]  o_clean_fail_cnt,
  output logic [CNT_W-1:0]  o_detected_cnt,
  output logic [CNT_W-1:0]  o_masked_cnt,
  output logic [CNT_W-1:0]  o_escape_cnt
);

  logic [CNT_W-1:0] r_clean_fail;
  logic [CNT_W-1:0] r_detected;
  logic [CNT_W-1:0] r_masked;
  logic [CNT_W-1:0] r_escape;

  // Clear on an accepted start, then bump exactly one counter per classified beat.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_clean_fail <= '0;
      r_detected   <= '0;
      r_masked     <= '0;
      r_escape     <= '0;
    end else if (i_clear) begin
      r_clean_fail <= '0;
      r_detected   <= '0;
      r_masked     <= '0;
      r_escape     <= '0;
    end else if (i_beat_vld) begin
      case (i_beat_class)
        CLEAN_FAIL: r_clean_fail <= r_clean_fail + 1'b1;
        DETECTED:   r_detected   <= r_detected + 1'b1;
        MASKED:     r_masked     <= r_masked + 1'b1;
        ESCAPE:     r_escape     <= r_escape + 1'b1;
        default:    ;
      endcase
    end
  end

  assign o_clean_fail_cnt = r_clean_fail;
  assign o_detected_cnt   = r_detected;
  assign o_masked_cnt     = r_masked;
  assign o_escape_cnt     = r_escape;

endmodule

// File: rtl/berger_mem_selftest_ctrl.sv
// rtl/berger_mem_selftest_ctrl.sv - Berger memory self-test sequencer; optional BERGER_CTRL_ESCAPE_LOG_EN first-escape log
module berger_mem_selftest_ctrl
  import berger_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [DATA_W-1:0]           i_cfg_pattern,
  input  logic [CODE_W-1:0]           i_cfg_fault_mask,
  input  logic                        i_cfg_zero_to_one,
  berger_mem_selftest_ctrl_if.master  mem_bus,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [CNT_W-1:0]            o_clean_fail_cnt,
  output logic [CNT_W-1:0]            o_detected_cnt,
  output logic [CNT_W-1:0]            o_masked_cnt,
  output logic [CNT_W-1:0]            o_escape_cnt,
  output logic                        o_escape_valid,
  output logic [ADDR_W-1:0]           o_escape_addr
);

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ISSUE_N = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(DEPTH + READ_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_step;
  logic [DATA_W-1:0]       r_pattern;
  logic [CODE_W-1:0]       r_mask;
  logic                    r_zero_to_one;
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [ADDR_W-1:0]       r_pipe_addr [READ_LATENCY];
  logic                    w_accept;
  logic                    w_issue;
  logic                    w_beat_vld;
  logic                    w_data_ok;
  logic [ADDR_W-1:0]       w_beat_addr;
  beat_class_t             w_beat_class;

  assign w_accept = (r_state == ST_IDLE) && i_start;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and memory-side outputs; the read phases run 16 issues plus a latency drain.
  always_comb begin
    w_state_nxt                = r_state;
    w_issue                    = 1'b0;
    mem_bus.mem_data           = '0;
    mem_bus.mem_addr           = '0;
    mem_bus.mem_wr_en          = 1'b0;
    mem_bus.fault_mask         = '0;
    mem_bus.fault_enable       = 1'b0;
    mem_bus.fault_zero_to_one  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        mem_bus.mem_wr_en = 1'b1;
        mem_bus.mem_addr  = r_step[ADDR_W-1:0];
        mem_bus.mem_data  = expected_data(r_pattern, r_step[ADDR_W-1:0]);
        if (r_step == WR_LAST) w_state_nxt = ST_RD_CLEAN;
      end
      ST_RD_CLEAN: begin
        w_issue = (r_step < ISSUE_N);
        if (w_issue) mem_bus.mem_addr = r_step[ADDR_W-1:0];
        if (r_step == RD_LAST) w_state_nxt = ST_RD_FAULT;
      end
      ST_RD_FAULT: begin
        w_issue                   = (r_step < ISSUE_N);
        mem_bus.fault_enable      = 1'b1;
        mem_bus.fault_mask        = r_mask;
        mem_bus.fault_zero_to_one = r_zero_to_one;
        if (w_issue) mem_bus.mem_addr = r_step[ADDR_W-1:0];
        if (r_step == RD_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Step counter restarts at every state change so each phase counts from zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                        r_step <= '0;
    else if (w_state_nxt != r_state)   r_step <= '0;
    else if (r_state != ST_IDLE)       r_step <= r_step + 1'b1;
  end

  // Configuration is frozen at the accepted start so mid-run input changes are ignored.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pattern     <= '0;
      r_mask        <= '0;
      r_zero_to_one <= 1'b0;
    end else if (w_accept) begin
      r_pattern     <= i_cfg_pattern;
      r_mask        <= i_cfg_fault_mask;
      r_zero_to_one <= i_cfg_zero_to_one;
    end
  end

  // Read-issue pipeline tracks which address each returning beat belongs to.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pipe_addr[i] <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_addr[0] <= mem_bus.mem_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  assign w_beat_vld  = r_pipe_vld[READ_LATENCY-1];
  assign w_beat_addr = r_pipe_addr[READ_LATENCY-1];
  assign w_data_ok   = (mem_bus.mem_rdata == expected_data(r_pattern, w_beat_addr));

  // Beats never straddle phases because each drain equals the read latency.
  always_comb begin
    w_beat_class = CLEAN_OK;
    if (r_state == ST_RD_FAULT) begin
      if (mem_bus.mem_error) w_beat_class = DETECTED;
      else if (w_data_ok)    w_beat_class = MASKED;
      else                   w_beat_class = ESCAPE;
    end else if (mem_bus.mem_error || !w_data_ok) begin
      w_beat_class = CLEAN_FAIL;
    end
  end

  berger_result_counter u_counter (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_clear          (w_accept),
    .i_beat_vld       (w_beat_vld),
    .i_beat_class     (w_beat_class),
    .o_clean_fail_cnt (o_clean_fail_cnt),
    .o_detected_cnt   (o_detected_cnt),
    .o_masked_cnt     (o_masked_cnt),
    .o_escape_cnt     (o_escape_cnt)
  );

`ifdef BERGER_CTRL_ESCAPE_LOG_EN
  logic              r_esc_vld;
  logic [ADDR_W-1:0] r_esc_addr;

  // Keep only the first escaping address of the run.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_esc_vld  <= 1'b0;
      r_esc_addr <= '0;
    end else if (w_accept) begin
      r_esc_vld  <= 1'b0;
      r_esc_addr <= '0;
    end else if (w_beat_vld && (w_beat_class == ESCAPE) && !r_esc_vld) begin
      r_esc_vld  <= 1'b1;
      r_esc_addr <= w_beat_addr;
    end
  end

  assign o_escape_valid = r_esc_vld;
  assign o_escape_addr  = r_esc_addr;
`else
  assign o_escape_valid = 1'b0;
  assign o_escape_addr  = '0;
`endif

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_berger_mem_selftest_ctrl.sv
// tb/tb_berger_mem_selftest_ctrl.sv - self-checking bench, latency 1 and 3 instances with a Berger memory path model
module tb_berger_mem_selftest_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [2];
  logic [7:0]  pat;
  logic [11:0] msk;
  logic        dir;
  int          stub_mode;

  logic        busy_v [2], done_v [2], escv_v [2], wr_v [2], fe_v [2];
  logic [4:0]  cf_v [2], det_v [2], mk_v [2], es_v [2];
  logic [3:0]  ea_v [2], addr_v [2];
  logic [11:0] fm_v [2];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done [2] = '{51, 55};

  always #5 clk = ~clk;

  function automatic logic [3:0] zeros8(input logic [7:0] d);
    return 4'(8 - $countones(d));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : 3;
    berger_mem_selftest_ctrl_if bus ();
    logic [11:0] mem [16];
    logic [7:0]  rd_pipe [RL];
    logic        err_pipe [RL];
    logic [11:0] cw_f;
    logic [7:0]  d_now;
    logic        e_now;

    berger_mem_selftest_ctrl #(.READ_LATENCY(RL)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[g]),
      .i_cfg_pattern(pat), .i_cfg_fault_mask(msk), .i_cfg_zero_to_one(dir),
      .mem_bus(bus),
      .o_busy(busy_v[g]), .o_done(done_v[g]),
      .o_clean_fail_cnt(cf_v[g]), .o_detected_cnt(det_v[g]),
      .o_masked_cnt(mk_v[g]), .o_escape_cnt(es_v[g]),
      .o_escape_valid(escv_v[g]), .o_escape_addr(ea_v[g])
    );

    always_comb begin
      cw_f = mem[bus.mem_addr];
      if (bus.fault_enable)
        cw_f = bus.fault_zero_to_one ? (cw_f | bus.fault_mask) : (cw_f & ~bus.fault_mask);
      d_now = cw_f[11:4];
      e_now = (zeros8(cw_f[11:4]) != cw_f[3:0]);
      if (bus.mem_addr == 4'd7 &&
          ((stub_mode == 1 && bus.fault_enable) || (stub_mode == 2 && !bus.fault_enable))) begin
        d_now = ~d_now;
        e_now = 1'b0;
      end
    end

    always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= {bus.mem_data, zeros8(bus.mem_data)};
      rd_pipe[0]  <= d_now;
      err_pipe[0] <= e_now;
      for (int i = 1; i < RL; i++) begin
        rd_pipe[i]  <= rd_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
      end
    end

    assign bus.mem_rdata = rd_pipe[RL-1];
    assign bus.mem_error = err_pipe[RL-1];
    assign wr_v[g]   = bus.mem_wr_en;
    assign fe_v[g]   = bus.fault_enable;
    assign addr_v[g] = bus.mem_addr;
    assign fm_v[g]   = bus.fault_mask;
  end

  int          done_cyc [2], done_w [2];
  logic        busy1 [2], busy_after [2], hold_ok [2], wr1 [2], fe_pre [2], fe_done [2];
  logic [3:0]  addr1 [2];
  logic [11:0] fm_pre [2];
  logic [4:0]  o_cf [2], o_det [2], o_mk [2], o_es [2];
  logic        o_ev [2];
  logic [3:0]  o_ea [2];

  task automatic ref_run(input logic [7:0] p, input logic [11:0] m, input logic z, input int mode,
                         output logic [4:0] cf, output logic [4:0] det, output logic [4:0] mk,
                         output logic [4:0] es, output logic ev, output logic [3:0] ea);
    cf = 0; det = 0; mk = 0; es = 0; ev = 0; ea = 0;
    for (int a = 0; a < 16; a++) begin
      logic [7:0]  d, fd;
      logic [11:0] cw;
      logic        err;
      d  = p ^ {a[3:0], a[3:0]};
      cw = {d, zeros8(d)};
      if (mode == 2 && a == 7) cf++;
      cw  = z ? (cw | m) : (cw & ~m);
      fd  = cw[11:4];
      err = (zeros8(fd) != cw[3:0]);
      if (mode == 1 && a == 7) begin fd = ~fd; err = 1'b0; end
      if (err) det++;
      else if (fd == d) mk++;
      else begin
        es++;
        if (!ev) begin ev = 1'b1; ea = a[3:0]; end
      end
    end
  endtask

  task automatic run_once(input logic [7:0] p, input logic [11:0] m, input logic z, input bit disturb);
    @(negedge clk);
    pat = p; msk = m; dir = z;
    start_v[0] = 1'b1; start_v[1] = 1'b1;
    for (int g = 0; g < 2; g++) begin done_cyc[g] = 0; done_w[g] = 0; hold_ok[g] = 0; busy_after[g] = 1; end
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        start_v[g] = disturb && (n == 5 || n == 50 || n == exp_done[g]);
      if (disturb && n == 10) begin pat = 8'($urandom); msk = 12'($urandom); dir = 1'($urandom); end
      for (int g = 0; g < 2; g++) begin
        if (n == 1) begin busy1[g] = busy_v[g]; wr1[g] = wr_v[g]; addr1[g] = addr_v[g]; end
        if (done_v[g]) done_w[g]++;
        if (done_cyc[g] != 0 && n == done_cyc[g] + 1) begin
          busy_after[g] = busy_v[g];
          hold_ok[g] = (cf_v[g] == o_cf[g]) && (det_v[g] == o_det[g]) &&
                       (mk_v[g] == o_mk[g]) && (es_v[g] == o_es[g]);
        end
        if (done_v[g] && done_cyc[g] == 0) begin
          done_cyc[g] = n; fe_done[g] = fe_v[g];
          o_cf[g] = cf_v[g]; o_det[g] = det_v[g]; o_mk[g] = mk_v[g]; o_es[g] = es_v[g];
          o_ev[g] = escv_v[g]; o_ea[g] = ea_v[g];
        end
        if (done_cyc[g] == 0) begin fe_pre[g] = fe_v[g]; fm_pre[g] = fm_v[g]; end
      end
      if (done_cyc[0] != 0 && done_cyc[1] != 0 && n >= done_cyc[0] + 3 && n >= done_cyc[1] + 3) break;
    end
    start_v[0] = 1'b0; start_v[1] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_v[0] = 1'b0; start_v[1] = 1'b0; pat = 0; msk = 0; dir = 0; stub_mode = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({busy_v[g], done_v[g], cf_v[g], det_v[g], mk_v[g], es_v[g], escv_v[g], ea_v[g],
           wr_v[g], fe_v[g], addr_v[g], fm_v[g]} !== '0) begin
        n_fail++; $display("FAIL reset_outputs inst%0d: some output nonzero, required all 0", g);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_fault_coverage();
    logic [7:0]  tp [9];
    logic [11:0] tm [9];
    logic        tz [9];
    int          tmode [9];
    logic [4:0]  e_cf, e_det, e_mk, e_es;
    logic        e_ev;
    logic [3:0]  e_ea;
    tp[0] = 8'h5A; tm[0] = 12'h000; tz[0] = 1; tmode[0] = 0;
    tp[1] = 8'hA5; tm[1] = 12'hFFF; tz[1] = 1; tmode[1] = 0;
    tp[2] = 8'h00; tm[2] = 12'hFFF; tz[2] = 0; tmode[2] = 0;
    for (int k = 3; k < 7; k++) begin
      tp[k] = 8'($urandom); tm[k] = 12'($urandom); tz[k] = 1'($urandom); tmode[k] = 0;
    end
    tp[7] = 8'($urandom); tm[7] = 12'h000; tz[7] = 1; tmode[7] = 1;
    tp[8] = 8'($urandom); tm[8] = 12'h000; tz[8] = 0; tmode[8] = 2;
    for (int k = 0; k < 9; k++) begin
      stub_mode = tmode[k];
      run_once(tp[k], tm[k], tz[k], 1'b0);
      ref_run(tp[k], tm[k], tz[k], tmode[k], e_cf, e_det, e_mk, e_es, e_ev, e_ea);
`ifndef BERGER_CTRL_ESCAPE_LOG_EN
      e_ev = 1'b0; e_ea = 4'd0;
`endif
      for (int g = 0; g < 2; g++) begin
        n_checks++;
        if (done_cyc[g] !== exp_done[g]) begin n_fail++;
          $display("FAIL done_cycle case%0d inst%0d got %0d want %0d", k, g, done_cyc[g], exp_done[g]); end
        n_checks++;
        if ({o_cf[g], o_det[g], o_mk[g], o_es[g]} !== {e_cf, e_det, e_mk, e_es}) begin n_fail++;
          $display("FAIL counts case%0d inst%0d got cf=%0d det=%0d mk=%0d es=%0d want cf=%0d det=%0d mk=%0d es=%0d",
                   k, g, o_cf[g], o_det[g], o_mk[g], o_es[g], e_cf, e_det, e_mk, e_es); end
        n_checks++;
        if ({o_ev[g], o_ea[g]} !== {e_ev, e_ea}) begin n_fail++;
          $display("FAIL escape_log case%0d inst%0d got v=%0b a=%0d want v=%0b a=%0d", k, g, o_ev[g], o_ea[g], e_ev, e_ea); end
        n_checks++;
        if ({busy1[g], wr1[g], addr1[g]} !== {1'b1, 1'b1, 4'd0}) begin n_fail++;
          $display("FAIL first_write case%0d inst%0d got busy=%0b wr=%0b addr=%0d want 1 1 0", k, g, busy1[g], wr1[g], addr1[g]); end
        n_checks++;
        if ({fe_pre[g], fm_pre[g], fe_done[g]} !== {1'b1, tm[k], 1'b0}) begin n_fail++;
          $display("FAIL fault_drive case%0d inst%0d got fe=%0b mask=%h fe_done=%0b want 1 %h 0", k, g, fe_pre[g], fm_pre[g], fe_done[g], tm[k]); end
        n_checks++;
        if ({done_w[g] == 1, busy_after[g], hold_ok[g]} !== 3'b101) begin n_fail++;
          $display("FAIL done_end case%0d inst%0d got width=%0d busy_after=%0b hold=%0b want 1 0 1", k, g, done_w[g], busy_after[g], hold_ok[g]); end
      end
    end
    stub_mode = 0;
  endtask

  task automatic test_start_ignored();
    logic [7:0]  p;
    logic [11:0] m;
    logic        z;
    logic [4:0]  e_cf, e_det, e_mk, e_es;
    logic        e_ev;
    logic [3:0]  e_ea;
    p = 8'($urandom); m = 12'($urandom); z = 1'($urandom);
    run_once(p, m, z, 1'b1);
    ref_run(p, m, z, 0, e_cf, e_det, e_mk, e_es, e_ev, e_ea);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({o_cf[g], o_det[g], o_mk[g], o_es[g]} !== {e_cf, e_det, e_mk, e_es}) begin n_fail++;
        $display("FAIL disturb_counts inst%0d got cf=%0d det=%0d mk=%0d es=%0d want cf=%0d det=%0d mk=%0d es=%0d",
                 g, o_cf[g], o_det[g], o_mk[g], o_es[g], e_cf, e_det, e_mk, e_es); end
      n_checks++;
      if ({done_cyc[g], done_w[g], 31'(busy_after[g])} !== {exp_done[g], 32'd1, 31'd0}) begin n_fail++;
        $display("FAIL disturb_timing inst%0d got done=%0d width=%0d busy_after=%0b want %0d 1 0",
                 g, done_cyc[g], done_w[g], busy_after[g], exp_done[g]); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] e_cf, e_det, e_mk, e_es;
    logic       e_ev;
    logic [3:0] e_ea;
    @(negedge clk);
    pat = 8'h3C; msk = 12'h0F0; dir = 1'b1; start_v[0] = 1'b1; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({busy_v[g], done_v[g], cf_v[g], det_v[g], mk_v[g], es_v[g], escv_v[g], ea_v[g],
           wr_v[g], fe_v[g], addr_v[g], fm_v[g]} !== '0) begin
        n_fail++; $display("FAIL midrun_reset inst%0d: busy=%0b cf=%0d some output nonzero, required all 0", g, busy_v[g], cf_v[g]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run_once(8'hC3, 12'h00F, 1'b0, 1'b0);
    ref_run(8'hC3, 12'h00F, 1'b0, 0, e_cf, e_det, e_mk, e_es, e_ev, e_ea);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({o_cf[g], o_det[g], o_mk[g], o_es[g], done_cyc[g]} !== {e_cf, e_det, e_mk, e_es, exp_done[g]}) begin n_fail++;
        $display("FAIL after_reset_run inst%0d got cf=%0d det=%0d mk=%0d es=%0d done=%0d want %0d %0d %0d %0d %0d",
                 g, o_cf[g], o_det[g], o_mk[g], o_es[g], done_cyc[g], e_cf, e_det, e_mk, e_es, exp_done[g]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fault_coverage();
    test_start_ignored();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
